// File: rtl/cpu_pkg.sv
// Shared RV32I decode definitions: opcodes, control encodings and the
// funct3 -> ALU operation helper used by both R-type and I-ALU decode.
package cpu_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_J,
    IMM_NONE
  } imm_src_t;

  typedef struct packed {
    logic      valid;
    alu_ctrl_t op;
  } alu_dec_t;

  // Only funct3 000 distinguishes add/sub; the I-ALU form passes sub=0.
  function automatic alu_dec_t decode_alu(input logic [2:0] funct3, input logic sub);
    alu_dec_t r;
    r.valid = 1'b1;
    r.op    = ALU_ADD;
    case (funct3)
      3'b000:  r.op = sub ? ALU_SUB : ALU_ADD;
      3'b111:  r.op = ALU_AND;
      3'b110:  r.op = ALU_OR;
      3'b010:  r.op = ALU_SLT;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile.sv
// 31 x 32-bit architectural registers (x0 hardwired to zero) with two
// combinational read ports that forward an in-flight writeback.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] regs [1:31];

  // NOTE: this storage is cleared by reset on purpose (architectural state
  // must read 0 after reset), so it is built from flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  // Forwarding stays active during reset; ra==0 short-circuits before the array.
  assign rd1 = (ra1 == 5'd0)              ? '0    :
               (we && waddr == ra1)       ? wdata : regs[ra1];
  assign rd2 = (ra2 == 5'd0)              ? '0    :
               (we && waddr == ra2)       ? wdata : regs[ra2];

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file with WB bypass, main control decode and
// immediate extension. All outputs are combinational from InstrD and W inputs.
module decode_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic [31:0] RD1D,
  output logic [31:0] RD2D,
  output logic [31:0] ImmExtD,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic [4:0]  RdD,
  output logic        RegWriteD,
  output logic [1:0]  ResultSrcD,
  output logic        MemWriteD,
  output logic        JumpD,
  output logic        BranchD,
  output logic        ALUSrcD,
  output logic [2:0]  ALUControlD,
  output logic        IllegalD
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  alu_dec_t    r_alu, i_alu;

  logic        reg_write, mem_write, jump, branch, alu_src, illegal;
  result_src_t result_src;
  alu_ctrl_t   alu_ctrl;
  imm_src_t    imm_src;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign Rs1D   = InstrD[19:15];
  assign Rs2D   = InstrD[24:20];
  assign RdD    = InstrD[11:7];

  assign r_alu = decode_alu(funct3, InstrD[30]);
  assign i_alu = decode_alu(funct3, 1'b0);

  regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (RegWriteW),
    .waddr (RdW),
    .wdata (ResultW),
    .ra1   (Rs1D),
    .ra2   (Rs2D),
    .rd1   (RD1D),
    .rd2   (RD2D)
  );

  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned (no latches); unsupported encodings just raise illegal.
  always_comb begin
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    jump       = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALU;
    alu_ctrl   = ALU_ADD;
    imm_src    = IMM_NONE;
    if (InstrD != 32'd0) begin
      case (opcode)
        OP_LOAD: begin
          reg_write  = 1'b1;
          result_src = RES_MEM;
          alu_src    = 1'b1;
          imm_src    = IMM_I;
        end
        OP_STORE: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
          imm_src   = IMM_S;
        end
        OP_R: begin
          if (r_alu.valid) begin
            reg_write = 1'b1;
            alu_ctrl  = r_alu.op;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_I: begin
          if (i_alu.valid) begin
            reg_write = 1'b1;
            alu_src   = 1'b1;
            alu_ctrl  = i_alu.op;
            imm_src   = IMM_I;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_BRANCH: begin
          if (funct3 == 3'b000) begin
            branch   = 1'b1;
            alu_ctrl = ALU_SUB;
            imm_src  = IMM_B;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_JAL: begin
          jump       = 1'b1;
          reg_write  = 1'b1;
          result_src = RES_PC4;
          imm_src    = IMM_J;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (imm_src)
      IMM_I:   ImmExtD = {{20{InstrD[31]}}, InstrD[31:20]};
      IMM_S:   ImmExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   ImmExtD = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      IMM_J:   ImmExtD = {{12{InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0};
      default: ImmExtD = '0;
    endcase
  end

  assign RegWriteD   = reg_write;
  assign ResultSrcD  = result_src;
  assign MemWriteD   = mem_write;
  assign JumpD       = jump;
  assign BranchD     = branch;
  assign ALUSrcD     = alu_src;
  assign ALUControlD = alu_ctrl;
  assign IllegalD    = illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed steps followed by random
// instructions/writebacks compared against a behavioural decode + regfile model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        we;
  logic [4:0]  rdw;
  logic [31:0] res;

  logic [31:0] rd1, rd2, imm;
  logic [4:0]  rs1, rs2, rdd;
  logic        regw, memw, jump, branch, alusrc, illegal;
  logic [1:0]  ressrc;
  logic [2:0]  aluc;

  int total = 0;
  int bad   = 0;

  logic [31:0] model [32];

  typedef struct {
    logic        rw;
    logic [1:0]  rs;
    logic        mw;
    logic        j;
    logic        br;
    logic        asrc;
    logic [2:0]  aluc;
    logic        ill;
    logic [31:0] imm;
  } exp_t;

  decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .InstrD      (instr),
    .RegWriteW   (we),
    .RdW         (rdw),
    .ResultW     (res),
    .RD1D        (rd1),
    .RD2D        (rd2),
    .ImmExtD     (imm),
    .Rs1D        (rs1),
    .Rs2D        (rs2),
    .RdD         (rdd),
    .RegWriteD   (regw),
    .ResultSrcD  (ressrc),
    .MemWriteD   (memw),
    .JumpD       (jump),
    .BranchD     (branch),
    .ALUSrcD     (alusrc),
    .ALUControlD (aluc),
    .IllegalD    (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(input logic f7b5, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {1'b0, f7b5, 5'b0, r2, r1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [31:0] im, input logic [4:0] r1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {im[11:0], r1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [31:0] im, input logic [4:0] r2, input logic [4:0] r1);
    return {im[11:5], r2, r1, 3'b010, im[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input logic [31:0] im, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3);
    return {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input logic [31:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6F};
  endfunction

  // Reference decode: immediates rebuilt by signed arithmetic on the fields.
  function automatic exp_t exp_decode(input logic [31:0] i);
    exp_t e;
    int   v;
    e = '{rw: 0, rs: 0, mw: 0, j: 0, br: 0, asrc: 0, aluc: 0, ill: 0, imm: 0};
    if (i == 32'd0) return e;
    case (i[6:0])
      7'h03: begin
        e.rw = 1; e.rs = 2'b01; e.asrc = 1;
        v = (i[31] ? -2048 : 0) + int'(i[30:20]);
        e.imm = v;
      end
      7'h23: begin
        e.mw = 1; e.asrc = 1;
        v = (i[31] ? -2048 : 0) + int'(i[30:25]) * 32 + int'(i[11:7]);
        e.imm = v;
      end
      7'h33, 7'h13: begin
        case (i[14:12])
          3'd0: e.aluc = (i[6:0] == 7'h33 && i[30]) ? 3'b001 : 3'b000;
          3'd7: e.aluc = 3'b010;
          3'd6: e.aluc = 3'b011;
          3'd2: e.aluc = 3'b101;
          default: e.ill = 1;
        endcase
        if (!e.ill) begin
          e.rw = 1;
          if (i[6:0] == 7'h13) begin
            e.asrc = 1;
            v = (i[31] ? -2048 : 0) + int'(i[30:20]);
            e.imm = v;
          end
        end else begin
          e.aluc = 0;
        end
      end
      7'h63: begin
        if (i[14:12] == 3'd0) begin
          e.br = 1; e.aluc = 3'b001;
          v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
          e.imm = v;
        end else begin
          e.ill = 1;
        end
      end
      7'h6F: begin
        e.j = 1; e.rw = 1; e.rs = 2'b10;
        v = (i[31] ? -(1 << 20) : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
        e.imm = v;
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (we && rdw == idx) return res;
    return model[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    exp_t e;
    e = exp_decode(instr);
    check({tag, ".rd1"},  rd1,    exp_read(instr[19:15]));
    check({tag, ".rd2"},  rd2,    exp_read(instr[24:20]));
    check({tag, ".rs1"},  32'(rs1), 32'(instr[19:15]));
    check({tag, ".rs2"},  32'(rs2), 32'(instr[24:20]));
    check({tag, ".rd"},   32'(rdd), 32'(instr[11:7]));
    check({tag, ".imm"},  imm,    e.imm);
    check({tag, ".rw"},   32'(regw),   32'(e.rw));
    check({tag, ".rsrc"}, 32'(ressrc), 32'(e.rs));
    check({tag, ".mw"},   32'(memw),   32'(e.mw));
    check({tag, ".jmp"},  32'(jump),   32'(e.j));
    check({tag, ".br"},   32'(branch), 32'(e.br));
    check({tag, ".asrc"}, 32'(alusrc), 32'(e.asrc));
    check({tag, ".aluc"}, 32'(aluc),   32'(e.aluc));
    check({tag, ".ill"},  32'(illegal), 32'(e.ill));
  endtask

  // Advance one edge, updating the model with what the DUT sees at that edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) model[k] = 32'd0;
    end else if (we && rdw != 5'd0) begin
      model[rdw] = res;
    end
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] i, input logic w,
                       input logic [4:0] d, input logic [31:0] v);
    rst = r; instr = i; we = w; rdw = d; res = v;
    #1;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) model[k] = 32'd0;
    drive(1'b1, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();

    // 1: reset state
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    check_outputs("rst_bubble");
    check("rst_bubble_imm", imm, 32'd0);
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, enc_r(1'b0, 5'(r), 5'(r), 3'd0, 5'd0), 1'b0, 5'd0, 32'd0);
      check("rst_rd1_zero", rd1, 32'd0);
      check("rst_rd2_zero", rd2, 32'd0);
    end

    // 2: write then read
    drive(1'b0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    drive(1'b0, enc_r(1'b0, 5'd0, 5'd5, 3'd0, 5'd6), 1'b0, 5'd0, 32'd0);
    check("wr_rd1", rd1, 32'hDEADBEEF);
    check("wr_rd2", rd2, 32'd0);
    check("wr_regw", 32'(regw), 32'd1);
    check("wr_aluc", 32'(aluc), 32'd0);
    check("wr_asrc", 32'(alusrc), 32'd0);
    check_outputs("wr");

    // 3: x0 protection and bypass
    drive(1'b0, enc_r(1'b0, 5'd0, 5'd0, 3'd0, 5'd1), 1'b1, 5'd0, 32'hFFFFFFFF);
    check("x0_bypass", rd1, 32'd0);
    tick();
    drive(1'b0, enc_r(1'b0, 5'd0, 5'd0, 3'd0, 5'd1), 1'b0, 5'd0, 32'd0);
    check("x0_stored", rd1, 32'd0);
    drive(1'b0, enc_r(1'b0, 5'd7, 5'd0, 3'd0, 5'd1), 1'b1, 5'd7, 32'h12);
    check("bypass_rs2", rd2, 32'h12);
    check_outputs("bypass");
    tick();
    drive(1'b0, enc_r(1'b0, 5'd7, 5'd7, 3'd0, 5'd1), 1'b1, 5'd7, 32'h34);
    check("b2b_inflight", rd1, 32'h34);
    tick();
    drive(1'b0, enc_r(1'b0, 5'd7, 5'd7, 3'd0, 5'd1), 1'b0, 5'd0, 32'd0);
    check("b2b_last_wins", rd2, 32'h34);

    // 4: immediates
    drive(1'b0, enc_i(32'hFFFFFFFC, 5'd2, 3'b010, 5'd1, 7'h03), 1'b0, 5'd0, 32'd0);
    check("imm_lw", imm, 32'hFFFFFFFC);
    check_outputs("lw");
    drive(1'b0, enc_s(32'd8, 5'd3, 5'd2), 1'b0, 5'd0, 32'd0);
    check("imm_sw", imm, 32'h00000008);
    check_outputs("sw");
    drive(1'b0, enc_b(32'hFFFFFFF8, 5'd3, 5'd2, 3'd0), 1'b0, 5'd0, 32'd0);
    check("imm_beq", imm, 32'hFFFFFFF8);
    check_outputs("beq");
    drive(1'b0, enc_j(32'h800, 5'd1), 1'b0, 5'd0, 32'd0);
    check("imm_jal", imm, 32'h00000800);
    check_outputs("jal");

    // 5: illegal encoding vs bubble
    drive(1'b0, 32'h0000007F, 1'b0, 5'd0, 32'd0);
    check("ill_flag", 32'(illegal), 32'd1);
    check_outputs("ill");
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    check("bubble_flag", 32'(illegal), 32'd0);
    check_outputs("bubble");

    // 6: reset mid-program with a coincident write
    drive(1'b0, 32'd0, 1'b1, 5'd10, 32'hCAFE0010);
    tick();
    drive(1'b1, 32'd0, 1'b1, 5'd3, 32'h0000ABCD);
    check_outputs("rst_mid_bypass");
    tick();
    for (int r = 1; r < 32; r++) begin
      drive(1'b0, enc_r(1'b0, 5'(r), 5'(r), 3'd0, 5'd0), 1'b0, 5'd0, 32'd0);
      check("rst_mid_rd1", rd1, 32'd0);
    end

    // Random phase
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ri;
      logic [4:0]  a, b, d;
      logic [31:0] rv;
      a  = 5'($urandom);
      b  = 5'($urandom);
      d  = 5'($urandom);
      rv = $urandom;
      case ($urandom_range(0, 7))
        0: ri = 32'd0;
        1: ri = enc_i(rv, a, 3'b010, d, 7'h03);
        2: ri = enc_s(rv, b, a);
        3: ri = enc_r(1'($urandom), b, a, 3'($urandom), d);
        4: ri = enc_i(rv, a, 3'($urandom), d, 7'h13);
        5: ri = enc_b(rv, b, a, ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'd0);
        6: ri = enc_j(rv, d);
        default: ri = $urandom;
      endcase
      drive(($urandom_range(0, 49) == 0), ri, 1'($urandom), 5'($urandom), $urandom);
      check_outputs("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
